// File: rtl/mmd_ratio_counter.sv
// Multi-modulus divider controller: adds the signed delta-sigma word to the
// integer divide word each period and counts that many Clk cycles.
module mmd_ratio_counter #(
    parameter int N_WIDTH = 8,
    parameter int MIN_DIV = 4
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic [N_WIDTH-1:0] N_Int,
    input  logic [4:0]         Dsm_Data,
    input  logic               Enable,
    output logic               Div_Out,
    output logic               Div_Pulse,
    output logic [N_WIDTH-1:0] Ratio_Out,
    output logic               Clamp_Err
);

    localparam int RW = N_WIDTH + 2;
    localparam logic signed [RW-1:0] MIN_S = RW'(MIN_DIV);
    localparam logic signed [RW-1:0] MAX_S = RW'((1 << N_WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT
    } state_t;

    state_t             state_q;
    logic [N_WIDTH-1:0] k_q;
    logic [N_WIDTH-1:0] ratio_q;
    logic               div_q;
    logic               pulse_q;
    logic               clamp_q;

    logic signed [RW-1:0] raw;
    logic [N_WIDTH-1:0]   ratio_d;
    logic                 clamp_d;
    logic [N_WIDTH:0]     half;
    logic [N_WIDTH-1:0]   k_d;
    logic                 div_d;
    logic                 last;

    always_comb begin
        raw = $signed({2'b00, N_Int})
            + $signed({{(RW-5){Dsm_Data[4]}}, Dsm_Data});
        ratio_d = raw[N_WIDTH-1:0];
        clamp_d = 1'b0;
        if (raw < MIN_S) begin
            ratio_d = N_WIDTH'(MIN_DIV);
            clamp_d = 1'b1;
        end else if (raw > MAX_S) begin
            ratio_d = '1;
            clamp_d = 1'b1;
        end
    end

    // High phase covers k < ceil(R/2); odd ratios get the extra cycle high
    always_comb begin
        half  = ({1'b0, ratio_q} + (N_WIDTH+1)'(1)) >> 1;
        k_d   = k_q + N_WIDTH'(1);
        div_d = ({1'b0, k_d} < half);
        last  = (k_q == ratio_q - N_WIDTH'(1));
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            ratio_q <= '0;
            div_q   <= 1'b0;
            pulse_q <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    k_q     <= '0;
                    div_q   <= 1'b0;
                    pulse_q <= 1'b0;
                    clamp_q <= 1'b0;
                    if (Enable) state_q <= LOAD;
                end
                LOAD: begin
                    state_q <= COUNT;
                    ratio_q <= ratio_d;
                    clamp_q <= clamp_q | clamp_d;
                    k_q     <= '0;
                    div_q   <= 1'b1;
                    pulse_q <= 1'b1;
                end
                COUNT: begin
                    if (last && Enable) begin
                        ratio_q <= ratio_d;
                        clamp_q <= clamp_q | clamp_d;
                        k_q     <= '0;
                        div_q   <= 1'b1;
                        pulse_q <= 1'b1;
                    end else if (last) begin
                        state_q <= IDLE;
                        k_q     <= '0;
                        div_q   <= 1'b0;
                        pulse_q <= 1'b0;
                        clamp_q <= 1'b0;
                    end else begin
                        k_q     <= k_d;
                        div_q   <= div_d;
                        pulse_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Div_Out   = div_q;
    assign Div_Pulse = pulse_q;
    assign Ratio_Out = ratio_q;
    assign Clamp_Err = clamp_q;

endmodule

// File: tb/tb_mmd_ratio_counter.sv
// Bench for mmd_ratio_counter: queue-based waveform reference model,
// directed cases, random stimulus and a closed MASH 1-1-1 loop.
module tb_mmd_ratio_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] n_int = '0;
    logic [4:0] dsm = '0;
    logic       en = 1'b0;
    logic       div_o;
    logic       pulse_o;
    logic [7:0] ratio_o;
    logic       clamp_o;

    int n_chk = 0;
    int n_err = 0;

    mmd_ratio_counter dut (
        .Clk       (clk),
        .reset     (rst_n),
        .N_Int     (n_int),
        .Dsm_Data  (dsm),
        .Enable    (en),
        .Div_Out   (div_o),
        .Div_Pulse (pulse_o),
        .Ratio_Out (ratio_o),
        .Clamp_Err (clamp_o)
    );

    always #5 clk = ~clk;

    // Reference: each period is a queue of output bits, one per cycle
    bit   m_q[$];
    bit   m_pend;
    bit   m_pulse;
    bit   m_clamp;
    int   m_r;

    function automatic int ratio_of(int n, int d);
        int raw = n + d;
        if (raw < 4) return 4;
        if (raw > 255) return 255;
        return raw;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pend  = 0;
            m_pulse = 0;
            m_clamp = 0;
            m_r     = 0;
        end else begin
            int raw;
            bit start;
            m_pulse = 0;
            start   = 0;
            if (m_pend) begin
                start  = 1;
                m_pend = 0;
            end else if (m_q.size() > 0) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    if (en) start = 1;
                    else m_clamp = 0;
                end
            end else if (en) begin
                m_pend = 1;
            end
            if (start) begin
                raw = int'(n_int) + int'($signed(dsm));
                m_r = ratio_of(int'(n_int), int'($signed(dsm)));
                if (raw != m_r) m_clamp = 1;
                for (int i = 0; i < m_r; i++)
                    m_q.push_back(i < (m_r + 1) / 2);
                m_pulse = 1;
            end
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(negedge clk);
            if (rst_n) begin
                chk("div", 32'(div_o),
                    32'(m_q.size() > 0 ? m_q[0] : 1'b0));
                chk("pulse", 32'(pulse_o), 32'(m_pulse));
                chk("ratio", 32'(ratio_o), 32'(m_r));
                chk("clamp", 32'(clamp_o), 32'(m_clamp));
            end
        end
    endtask

    task automatic wait_pulse();
        int t = 0;
        do begin
            cyc(1);
            t++;
        end while (!pulse_o && t < 600);
        if (!pulse_o) chk("pulse_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    int tn[6] = '{10, 15, 9, 2, 254, 30};
    int td[6] = '{4, -3, 0, -3, 4, 1};
    int tr[6] = '{14, 12, 9, 4, 255, 31};
    int tc[6] = '{0, 0, 0, 1, 1, 1};

    longint a1, a2, a3;
    int c2d, c3d, c3dd;

    function automatic int mash_step();
        longint s;
        int c1, c2, c3, y;
        s = a1 + 64'h800000; c1 = int'(s >> 24); a1 = s & 64'hFFFFFF;
        s = a2 + a1;         c2 = int'(s >> 24); a2 = s & 64'hFFFFFF;
        s = a3 + a2;         c3 = int'(s >> 24); a3 = s & 64'hFFFFFF;
        y = c1 + c2 - c2d + c3 - 2 * c3d + c3dd;
        c2d = c2; c3dd = c3d; c3d = c3;
        return y;
    endfunction

    initial begin
        int hi, lo, t, pulses, cyc_cnt, exp_cnt, rmin, rmax, y;

        // Reset state
        cyc(2);
        chk("rst_div", 32'(div_o), 0);
        chk("rst_ratio", 32'(ratio_o), 0);
        chk("rst_clamp", 32'(clamp_o), 0);
        rst_n = 1'b1;
        cyc(1);

        // Integer ratio 16, first rise two edges after Enable
        n_int = 8'd16; dsm = 5'd0; en = 1'b1;
        cyc(1);
        chk("load_div", 32'(div_o), 0);
        cyc(1);
        chk("first_rise", 32'(div_o), 1);
        chk("ratio16", 32'(ratio_o), 16);
        hi = 0; lo = 0; t = 0;
        while (div_o && t < 40) begin hi++; cyc(1); t++; end
        while (!div_o && t < 40) begin lo++; cyc(1); t++; end
        chk("high16", 32'(hi), 8);
        chk("low16", 32'(lo), 8);

        // Signed sums and clamps; each value takes hold a period later
        for (int i = 0; i < 6; i++) begin
            wait_pulse();
            cyc(2);
            n_int = 8'(tn[i]);
            dsm   = 5'(td[i]);
            wait_pulse();
            wait_pulse();
            chk("case_ratio", 32'(ratio_o), 32'(tr[i]));
            chk("case_clamp", 32'(clamp_o), 32'(tc[i]));
        end

        // Enable removal at k=5 finishes a ratio-20 period, then idle
        n_int = 8'd20; dsm = 5'd0;
        wait_pulse();
        wait_pulse();
        cyc(5);
        en = 1'b0;
        cyc(14);
        chk("hold_last", 32'(div_o), 0);
        cyc(1);
        chk("idle_div", 32'(div_o), 0);
        chk("idle_clamp", 32'(clamp_o), 0);
        pulses = 0;
        repeat (25) begin cyc(1); pulses += int'(pulse_o); end
        chk("idle_pulses", 32'(pulses), 0);
        chk("idle_ratio", 32'(ratio_o), 20);

        // Re-assert Enable at k=R-1: no gap
        en = 1'b1;
        wait_pulse();
        cyc(5);
        en = 1'b0;
        cyc(14);
        en = 1'b1;
        cyc(1);
        chk("no_gap", 32'(pulse_o), 1);

        // Asynchronous reset at k=7 of a ratio-16 period
        n_int = 8'd16;
        wait_pulse();
        wait_pulse();
        cyc(7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_div", 32'(div_o), 0);
        chk("arst_pulse", 32'(pulse_o), 0);
        chk("arst_ratio", 32'(ratio_o), 0);
        chk("arst_clamp", 32'(clamp_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        chk("rel_load", 32'(div_o), 0);
        cyc(1);
        chk("rel_rise", 32'(div_o), 1);

        // Random stimulus
        for (int i = 0; i < 300; i++) begin
            t = int'($urandom_range(0, 9));
            if (t == 0) n_int = 8'($urandom_range(0, 3));
            else if (t == 1) n_int = 8'($urandom_range(250, 255));
            else n_int = 8'($urandom_range(4, 40));
            dsm = 5'($urandom_range(0, 7) - 3);
            en  = ($urandom_range(0, 99) < 85);
            cyc(int'($urandom_range(1, 30)));
        end

        // Closed loop with a MASH 1-1-1 at half-LSB input
        do_reset();
        a1 = 0; a2 = 0; a3 = 0; c2d = 0; c3d = 0; c3dd = 0;
        n_int = 8'd20; dsm = 5'd0; en = 1'b1;
        wait_pulse();
        pulses = 0; cyc_cnt = 0; exp_cnt = 20;
        rmin = 255; rmax = 0;
        y = mash_step();
        dsm = 5'(y);
        while (pulses < 512 && cyc_cnt < 20000) begin
            cyc(1);
            cyc_cnt++;
            if (pulse_o) begin
                pulses++;
                if (ratio_o < rmin) rmin = int'(ratio_o);
                if (ratio_o > rmax) rmax = int'(ratio_o);
                if (pulses < 512) exp_cnt += ratio_of(20, y);
                y = mash_step();
                dsm = 5'(y);
            end
        end
        chk("loop_periods", 32'(pulses), 512);
        chk("loop_cycles", 32'(cyc_cnt), 32'(exp_cnt));
        chk("loop_mean", 32'(cyc_cnt >= 10492 && cyc_cnt <= 10500), 1);
        chk("loop_rmin", 32'(rmin >= 17), 1);
        chk("loop_rmax", 32'(rmax <= 24), 1);
        chk("loop_clamp", 32'(clamp_o), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
